// File: rtl/ifmap_pkg.sv
// Shared types and helpers for the IFMap row packer: FSM states, flag bit positions and
// the output word builder.
package ifmap_pkg;

  localparam int unsigned IFMAP_DATA_W  = 16;
  localparam int unsigned IFMAP_WORD_W  = IFMAP_DATA_W + 2;
  localparam int unsigned START_ROW_BIT = IFMAP_WORD_W - 1;
  localparam int unsigned END_ROW_BIT   = IFMAP_WORD_W - 2;

  typedef enum logic [2:0] {
    StIdle,
    StPadL,
    StStream,
    StPadR,
    StDone
  } state_e;

  function automatic logic [IFMAP_WORD_W-1:0] pack_word(input logic start_row,
                                                        input logic end_row,
                                                        input logic [IFMAP_DATA_W-1:0] data);
    logic [IFMAP_WORD_W-1:0] w;
    w                     = '0;
    w[START_ROW_BIT]      = start_row;
    w[END_ROW_BIT]        = end_row;
    w[IFMAP_DATA_W-1:0]   = data;
    return w;
  endfunction

endpackage

// File: rtl/ifmap_out_stage.sv
// Single-entry output register feeding the IFMap buffer; advances whenever it is empty or
// the buffer can take the held word.
module ifmap_out_stage
  import ifmap_pkg::*;
#(
  parameter int unsigned Width = IFMAP_WORD_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] word_i,
  input  logic             buf_full_i,
  output logic             adv_o,
  output logic             wen_o,
  output logic [Width-1:0] word_o
);

  logic             valid_q;
  logic [Width-1:0] word_q;

  assign adv_o  = !valid_q || !buf_full_i;
  assign wen_o  = valid_q && !buf_full_i;
  assign word_o = word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (adv_o) begin
      valid_q <= load_i;
      if (load_i) begin
        word_q <= word_i;
      end
    end
  end

endmodule

// File: rtl/ifmap_row_packer.sv
// Packs a pixel stream into {start_row, end_row, pixel} words for the IFMap buffer.
// Optional zero padding on both row ends is built only with IFMAP_PACKER_PAD_EN defined.
module ifmap_row_packer
  import ifmap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = IFMAP_DATA_W,
  parameter int unsigned IFMAP_WIDTH  = IFMAP_WORD_W,
  parameter int unsigned ROW_LEN_SIZE = 8,
  parameter int unsigned ROW_CNT_SIZE = 8
`ifdef IFMAP_PACKER_PAD_EN
  ,
  parameter int unsigned PAD_SIZE     = 2
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ROW_LEN_SIZE-1:0] row_len,
  input  logic [ROW_CNT_SIZE-1:0] row_count,
`ifdef IFMAP_PACKER_PAD_EN
  input  logic [PAD_SIZE-1:0]     pad_len,
`endif
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    buf_full,
  output logic [IFMAP_WIDTH-1:0]  IFMap_out,
  output logic                    wen_IFMap_buffer,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cfg
);

  state_e                  state_q;
  logic [ROW_LEN_SIZE-1:0] row_len_q, col_cnt_q;
  logic [ROW_CNT_SIZE-1:0] row_count_q, row_cnt_q;
  logic                    err_cfg_q;

  logic                    adv, wen, load, accept;
  logic                    cfg_ok, col_last, row_last, row_end, has_pad;
  logic [IFMAP_WIDTH-1:0]  load_word;

`ifdef IFMAP_PACKER_PAD_EN
  logic [PAD_SIZE-1:0]     pad_len_q, pad_cnt_q;
  logic                    pad_last;

  assign has_pad  = (pad_len_q != '0);
  assign pad_last = (pad_cnt_q == pad_len_q - PAD_SIZE'(1));
  assign row_end  = (state_q == StStream && accept && col_last && !has_pad) ||
                    (state_q == StPadR && adv && pad_last);
`else
  assign has_pad  = 1'b0;
  assign row_end  = (state_q == StStream) && accept && col_last;
`endif

  assign cfg_ok   = (row_len != '0) && (row_count != '0);
  assign col_last = (col_cnt_q == row_len_q - ROW_LEN_SIZE'(1));
  assign row_last = (row_cnt_q == row_count_q - ROW_CNT_SIZE'(1));

  assign pix_ready = (state_q == StStream) && adv;
  assign accept    = pix_valid && pix_ready;

  // Word offered to the output register; it only takes effect on an adv cycle.
  always_comb begin
    load      = 1'b0;
    load_word = '0;
    case (state_q)
      StStream: begin
        if (pix_valid) begin
          load      = 1'b1;
          load_word = pack_word((col_cnt_q == '0) && !has_pad, col_last && !has_pad, pix_in);
        end
      end
`ifdef IFMAP_PACKER_PAD_EN
      StPadL: begin
        load      = 1'b1;
        load_word = pack_word(pad_cnt_q == '0, 1'b0, '0);
      end
      StPadR: begin
        load      = 1'b1;
        load_word = pack_word(1'b0, pad_last, '0);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      row_len_q   <= '0;
      row_count_q <= '0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      err_cfg_q   <= 1'b0;
`ifdef IFMAP_PACKER_PAD_EN
      pad_len_q   <= '0;
      pad_cnt_q   <= '0;
`endif
    end else begin
      err_cfg_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_ok) begin
              row_len_q   <= row_len;
              row_count_q <= row_count;
              col_cnt_q   <= '0;
              row_cnt_q   <= '0;
`ifdef IFMAP_PACKER_PAD_EN
              pad_len_q   <= pad_len;
              pad_cnt_q   <= '0;
              state_q     <= (pad_len != '0) ? StPadL : StStream;
`else
              state_q     <= StStream;
`endif
            end else begin
              err_cfg_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (accept) begin
            col_cnt_q <= col_last ? '0 : col_cnt_q + ROW_LEN_SIZE'(1);
`ifdef IFMAP_PACKER_PAD_EN
            if (col_last && has_pad) begin
              state_q <= StPadR;
            end
`endif
          end
        end
`ifdef IFMAP_PACKER_PAD_EN
        StPadL: begin
          if (adv) begin
            if (pad_last) begin
              pad_cnt_q <= '0;
              state_q   <= StStream;
            end else begin
              pad_cnt_q <= pad_cnt_q + PAD_SIZE'(1);
            end
          end
        end
        StPadR: begin
          if (adv) begin
            pad_cnt_q <= pad_last ? '0 : pad_cnt_q + PAD_SIZE'(1);
          end
        end
`endif
        StDone: begin
          if (wen) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Row completion overrides the per-state transition above.
      if (row_end) begin
        row_cnt_q <= row_cnt_q + ROW_CNT_SIZE'(1);
        col_cnt_q <= '0;
        if (row_last) begin
          state_q <= StDone;
        end else begin
          state_q <= has_pad ? StPadL : StStream;
        end
      end
    end
  end

  ifmap_out_stage #(
    .Width(IFMAP_WIDTH)
  ) u_out_stage (
    .clk_i     (clk),
    .rst_ni    (rstn),
    .load_i    (load),
    .word_i    (load_word),
    .buf_full_i(buf_full),
    .adv_o     (adv),
    .wen_o     (wen),
    .word_o    (IFMap_out)
  );

  assign wen_IFMap_buffer = wen;
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StDone) && wen;
  assign err_cfg          = err_cfg_q;

endmodule

// File: doc/ifmap_row_packer.md
# ifmap_row_packer

Upstream feeder for the PE datapath's IFMap FIFO. Accepts a raw pixel stream over valid/ready, counts columns and rows against a latched frame geometry, and emits IFMAP_WIDTH-bit words `{start_row, end_row, pixel}` into the IFMap buffer. Writes are throttled by the buffer's full flag. The PE read controller relies on the end_row flag at bit IFMAP_WIDTH-2 to detect row boundaries.

## Interface
- DATA_WIDTH, 16, pixel width.
- IFMAP_WIDTH, 18, output word width; must equal DATA_WIDTH+2.
- ROW_LEN_SIZE, 8, width of the row-length config and column counter.
- ROW_CNT_SIZE, 8, width of the row-count config and row counter.
- PAD_SIZE, 2, width of the pad-length config (used only with the padding macro).
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; latches config and begins a frame. Honoured in IDLE only.
- row_len  in  ROW_LEN_SIZE  pixels per row.
- row_count  in  ROW_CNT_SIZE  rows per frame.
- pad_len  in  PAD_SIZE  zero words on each side of a row (padding macro only).
- pix_in  in  DATA_WIDTH  pixel data.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  packer accepts pix_in this cycle.
- buf_full  in  1  IFMap buffer is full.
- IFMap_out  out  IFMAP_WIDTH  bit IFMAP_WIDTH-1 = start_row, bit IFMAP_WIDTH-2 = end_row, bits [DATA_WIDTH-1:0] = data.
- wen_IFMap_buffer  out  1  write strobe to the IFMap buffer.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse on the final write of the frame.
- err_cfg  out  1  one-cycle pulse when start arrives with row_len==0 or row_count==0.

## Operation
- FSM states: IDLE, PAD_L, STREAM, PAD_R, DONE.
- IDLE:
  - On start with valid config, latch row_len, row_count and pad_len; clear col_cnt, row_cnt and pad_cnt; go to PAD_L if pad_len!=0, otherwise STREAM.
  - On start with an invalid config, pulse err_cfg and stay in IDLE.
- Output stage is a single register holding (word, out_valid).
  - adv = !out_valid || !buf_full.
  - wen_IFMap_buffer = out_valid && !buf_full.
  - On adv, the register loads the next word or clears out_valid.
- PAD_L / PAD_R: emit one zero-data word per adv cycle; pad_cnt counts to pad_len and then the FSM moves on. pix_ready = 0 in these states.
- STREAM: pix_ready = adv. Each pix_valid && pix_ready loads pix_in and increments col_cnt. After the row_len-th pixel, move to PAD_R (pad_len!=0) or end the row.
- Flags:
  - start_row = 1 on the first word of each row, which is the pad word when padding is present.
  - end_row = 1 on the last word of each row.
  - With row_len=1 and no pad, both flags are set on the same word.
- End of row: increment row_cnt and clear col_cnt/pad_cnt. If row_cnt reaches row_count go to DONE, otherwise return to PAD_L/STREAM.
- DONE: wait until out_valid has drained (final write accepted), pulse done in that write cycle, then go to IDLE.
- busy: 1 from the cycle after a valid start through the done cycle inclusive.
- Counters never wrap within a frame; widths come from the parameters.

## Timing
- Reset values: IFMap_out=0, wen_IFMap_buffer=0, pix_ready=0, busy=0, done=0, err_cfg=0, FSM=IDLE. Reset applies asynchronously mid-frame and discards any held word.
- Latency: a pixel accepted in cycle N is written (wen high) in cycle N+1 if buf_full=0.
- With buf_full=0 and pix_valid held high, throughput is 1 word/cycle including pad words.
- buf_full high: the word is held stable, wen=0, pix_ready=0. Data is never dropped or duplicated.
- buf_full dropping while pix_valid=1: the held word writes and a new pixel is accepted in the same cycle.
- start while busy: ignored, with no err_cfg pulse.

## Configuration
- IFMAP_PACKER_PAD_EN defined: pad_len port, PAD_L/PAD_R states and pad_cnt are present.
- IFMAP_PACKER_PAD_EN undefined: pad_len port is absent, PAD states are unreachable and not synthesised, and rows hold exactly row_len words.

## Structure
- Shared package ifmap_pkg:
  - state enum.
  - START_ROW_BIT / END_ROW_BIT localparams derived from IFMAP_WIDTH.
  - function building the output word from flags and data.
- One sub-module, ifmap_out_stage: the output register with adv/wen logic.

## Test plan
- row_len=4, row_count=2, no pad, pixels 1..8, buf_full=0 -> 8 writes with flags S,-,-,E per row; done coincides with the write of 8; busy spans 9 cycles.
- row_len=1, row_count=3 -> 3 writes, each with start_row=1 and end_row=1.
- buf_full held high for 5 cycles mid-row -> IFMap_out stable, wen=0, pix_ready=0; output order after release is unchanged.
- PAD_EN, pad_len=1, row_len=2, pixels A,B -> words 0(S), A, B, 0(E).
- start with row_len=0 -> err_cfg pulses once and busy stays 0. Separately, start during a frame is ignored.
- rstn asserted after 3 of 8 pixels -> all outputs 0 immediately; a new start then streams a full frame correctly.
